// File: rtl/udma_traffic_gen_rx_param_if.sv
// -----------------------------------------------------------------------------
// udma_traffic_gen_rx_param_if
// Valid/ready word stream between the RX traffic generator and the uDMA RX
// channel input.
//   rx_data  : generated word (DATA_WIDTH bits)
//   rx_valid : word offered
//   rx_ready : downstream accepts the offered word
// Modports: master = generator side, slave = RX channel side.
// -----------------------------------------------------------------------------
interface udma_traffic_gen_rx_param_if #(
  parameter int DATA_WIDTH = 32
);
  logic [DATA_WIDTH-1:0] rx_data;
  logic                  rx_valid;
  logic                  rx_ready;

  modport master (output rx_data, output rx_valid, input rx_ready);
  modport slave  (input rx_data, input rx_valid, output rx_ready);
endinterface

// File: rtl/udma_traffic_gen_rx_param.sv
// -----------------------------------------------------------------------------
// udma_traffic_gen_rx_param
// Parametrised uDMA RX-side traffic generator. After software enable it emits
// cfg_len_i synthetic words (increment, decrement, Galois LFSR or constant)
// on a valid/ready stream, pulses done_o after the last accepted word, then
// waits for the enable to be cleared.
//
// Build option: define TRAFFIC_GEN_GAP_EN to implement the inter-word gap
// (cfg_setup_i[15:8] idle cycles between words). Without it words are
// offered back-to-back and the gap field is ignored.
//
// Ports:
//   clk_i, rstn_i  clock, asynchronous active-low reset
//   cfg_setup_i    [0] enable, [2:1] mode, [15:8] gap cycles
//   cfg_init_i     first word / LFSR seed
//   cfg_len_i      number of words per run
//   busy_o         high in GENERATE or GAP
//   done_o         one-cycle pulse after the last accepted word
//   count_o        words accepted in the current or last run
//   rx             stream master (rx_data, rx_valid out; rx_ready in)
// -----------------------------------------------------------------------------
module udma_traffic_gen_rx_param #(
  parameter int          DATA_WIDTH = 32,
  parameter int          CNT_WIDTH  = 16,
  parameter logic [31:0] LFSR_POLY  = 32'h8020_0003
) (
  input  logic                        clk_i,
  input  logic                        rstn_i,
  input  logic [31:0]                 cfg_setup_i,
  input  logic [DATA_WIDTH-1:0]       cfg_init_i,
  input  logic [CNT_WIDTH-1:0]        cfg_len_i,
  output logic                        busy_o,
  output logic                        done_o,
  output logic [CNT_WIDTH-1:0]        count_o,
  udma_traffic_gen_rx_param_if.master rx
);

  localparam logic [1:0] MODE_INC  = 2'b00;
  localparam logic [1:0] MODE_DEC  = 2'b01;
  localparam logic [1:0] MODE_LFSR = 2'b10;

  // Only the low DATA_WIDTH bits of the polynomial take part in feedback.
  localparam logic [DATA_WIDTH-1:0] POLY_MASK = DATA_WIDTH'(LFSR_POLY);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_GEN  = 2'd1,
`ifdef TRAFFIC_GEN_GAP_EN
    ST_GAP  = 2'd2,
`endif
    ST_WAIT = 2'd3
  } state_e;

  state_e                state_q;
  logic [DATA_WIDTH-1:0] data_q;
  logic                  valid_q;
  logic                  done_q;
  logic [CNT_WIDTH-1:0]  count_q;
  logic [CNT_WIDTH-1:0]  len_q;
  logic [1:0]            mode_q;
`ifdef TRAFFIC_GEN_GAP_EN
  logic [7:0]            gap_q;
  logic [7:0]            gap_cnt_q;
`endif

  logic                  en;
  logic [1:0]            mode_in;
  logic [DATA_WIDTH-1:0] seed_d;
  logic [DATA_WIDTH-1:0] data_nxt_d;
  logic [CNT_WIDTH-1:0]  cnt_inc_d;
  logic                  hs;

  function automatic logic [DATA_WIDTH-1:0] next_word(
    input logic [1:0]            mode,
    input logic [DATA_WIDTH-1:0] d
  );
    case (mode)
      MODE_INC:  return d + DATA_WIDTH'(1);
      MODE_DEC:  return d - DATA_WIDTH'(1);
      MODE_LFSR: return (d >> 1) ^ (d[0] ? POLY_MASK : '0);
      default:   return d;
    endcase
  endfunction

  assign en         = cfg_setup_i[0];
  assign mode_in    = cfg_setup_i[2:1];
  // An all-zero LFSR state would lock up, so a zero seed starts at 1.
  assign seed_d     = (mode_in == MODE_LFSR && cfg_init_i == '0) ? DATA_WIDTH'(1) : cfg_init_i;
  assign data_nxt_d = next_word(mode_q, data_q);
  assign cnt_inc_d  = count_q + CNT_WIDTH'(1);
  assign hs         = valid_q & rx.rx_ready;

`ifdef TRAFFIC_GEN_GAP_EN
  logic unused_cfg;
  assign unused_cfg = ^{cfg_setup_i[31:16], cfg_setup_i[7:3]};
  assign busy_o     = (state_q == ST_GEN) || (state_q == ST_GAP);
`else
  logic unused_cfg;
  assign unused_cfg = ^{cfg_setup_i[31:3]};
  assign busy_o     = (state_q == ST_GEN);
`endif

  assign done_o      = done_q;
  assign count_o     = count_q;
  assign rx.rx_data  = data_q;
  assign rx.rx_valid = valid_q;

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_q   <= ST_IDLE;
      data_q    <= '0;
      valid_q   <= 1'b0;
      done_q    <= 1'b0;
      count_q   <= '0;
      len_q     <= '0;
      mode_q    <= MODE_INC;
`ifdef TRAFFIC_GEN_GAP_EN
      gap_q     <= '0;
      gap_cnt_q <= '0;
`endif
    end else begin
      done_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (en) begin
            mode_q  <= mode_in;
            len_q   <= cfg_len_i;
            count_q <= '0;
            data_q  <= seed_d;
`ifdef TRAFFIC_GEN_GAP_EN
            gap_q   <= cfg_setup_i[15:8];
`endif
            if (cfg_len_i == '0) begin
              state_q <= ST_WAIT;
              done_q  <= 1'b1;
            end else begin
              state_q <= ST_GEN;
              valid_q <= 1'b1;
            end
          end
        end

        ST_GEN: begin
          if (hs) begin
            count_q <= cnt_inc_d;
            data_q  <= data_nxt_d;
            // An abort only takes effect once the offered word is accepted,
            // and never reports completion.
            if (!en) begin
              state_q <= ST_IDLE;
              valid_q <= 1'b0;
            end else if (cnt_inc_d == len_q) begin
              state_q <= ST_WAIT;
              valid_q <= 1'b0;
              done_q  <= 1'b1;
            end
`ifdef TRAFFIC_GEN_GAP_EN
            else if (gap_q != '0) begin
              state_q   <= ST_GAP;
              valid_q   <= 1'b0;
              gap_cnt_q <= gap_q;
            end
`endif
          end else if (!valid_q && !en) begin
            state_q <= ST_IDLE;
          end
        end

`ifdef TRAFFIC_GEN_GAP_EN
        ST_GAP: begin
          // gap_cnt_q counts the idle cycles still to elapse, including this one.
          if (!en) begin
            state_q <= ST_IDLE;
          end else if (gap_cnt_q == 8'd1) begin
            state_q <= ST_GEN;
            valid_q <= 1'b1;
          end else begin
            gap_cnt_q <= gap_cnt_q - 8'd1;
          end
        end
`endif

        ST_WAIT: begin
          if (!en) state_q <= ST_IDLE;
        end

        default: begin
          state_q <= ST_IDLE;
          valid_q <= 1'b0;
        end
      endcase
    end
  end

endmodule
